// File: rtl/arm_control_unit.sv
// Single-cycle ARM-subset controller: decodes Instr against the stored NZCV flags.
// Optional macro ARM_CTRL_CMP_EN adds CMP/CMN (cmd 1010/1011 with S=1) decode.
module arm_control_unit #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        PCSrc,
  output logic [3:0]  Flags
);

  logic [3:0] r_flags;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [3:0] w_rd;
  logic       w_unused;

  logic       w_mainRegW;
  logic       w_regW;
  logic       w_memW;
  logic       w_branch;
  logic       w_aluOp;
  logic [1:0] w_flagW;
  logic       w_pcs;
  logic       w_condEx;
  logic       w_n, w_z, w_c, w_v;

  assign w_cond   = Instr[31:28];
  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_cmd    = w_funct[4:1];
  assign w_s      = w_funct[0];
  assign w_rd     = Instr[15:12];
  assign w_unused = ^{Instr[19:16], Instr[11:0]};

  always_comb begin
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    w_mainRegW = 1'b0;
    w_memW     = 1'b0;
    w_branch   = 1'b0;
    w_aluOp    = 1'b0;
    case (w_op)
      2'b00: begin
        ALUSrc     = w_funct[5];
        w_mainRegW = 1'b1;
        w_aluOp    = 1'b1;
      end
      2'b01: begin
        ImmSrc = 2'b01;
        ALUSrc = 1'b1;
        if (w_funct[0]) begin
          MemtoReg   = 1'b1;
          w_mainRegW = 1'b1;
        end else begin
          RegSrc = 2'b10;
          w_memW = 1'b1;
        end
      end
      2'b10: begin
        RegSrc   = 2'b01;
        ImmSrc   = 2'b10;
        ALUSrc   = 1'b1;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Unsupported data-processing commands become NOPs: no register or flag write.
  always_comb begin
    ALUControl = 2'b00;
    w_flagW    = 2'b00;
    w_regW     = w_mainRegW;
    if (w_aluOp) begin
      case (w_cmd)
        4'b0100: begin ALUControl = 2'b00; w_flagW = {w_s, w_s};  end
        4'b0010: begin ALUControl = 2'b01; w_flagW = {w_s, w_s};  end
        4'b0000: begin ALUControl = 2'b10; w_flagW = {w_s, 1'b0}; end
        4'b1100: begin ALUControl = 2'b11; w_flagW = {w_s, 1'b0}; end
`ifdef ARM_CTRL_CMP_EN
        4'b1010: begin
          w_regW = 1'b0;
          if (w_s) begin
            ALUControl = 2'b01;
            w_flagW    = 2'b11;
          end
        end
        4'b1011: begin
          w_regW = 1'b0;
          if (w_s) begin
            ALUControl = 2'b00;
            w_flagW    = 2'b11;
          end
        end
`endif
        default: w_regW = 1'b0;
      endcase
    end
  end

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condEx = 1'b0;
    case (w_cond)
      4'h0: w_condEx = w_z;
      4'h1: w_condEx = ~w_z;
      4'h2: w_condEx = w_c;
      4'h3: w_condEx = ~w_c;
      4'h4: w_condEx = w_n;
      4'h5: w_condEx = ~w_n;
      4'h6: w_condEx = w_v;
      4'h7: w_condEx = ~w_v;
      4'h8: w_condEx = w_c & ~w_z;
      4'h9: w_condEx = ~w_c | w_z;
      4'hA: w_condEx = (w_n == w_v);
      4'hB: w_condEx = (w_n != w_v);
      4'hC: w_condEx = ~w_z & (w_n == w_v);
      4'hD: w_condEx = w_z | (w_n != w_v);
      4'hE: w_condEx = 1'b1;
      default: w_condEx = 1'b0;
    endcase
  end

  assign w_pcs    = w_branch | (w_regW & (w_rd == 4'hF));
  assign RegWrite = w_regW & w_condEx;
  assign MemWrite = w_memW & w_condEx;
  assign PCSrc    = w_pcs & w_condEx;
  assign Flags    = r_flags;

  // NZ and CV halves update independently so logical ops leave C/V intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= FLAGS_RESET;
    end else begin
      if (w_flagW[1] & w_condEx) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagW[0] & w_condEx) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule
